cast_gather: RTL

Tile-side deserializer on the inbound cast path. It consumes the one-word-per-handshake stream that the network interface delivers into the tile clock domain. It assembles `valid_chans` consecutive words into one `XW`-lane vector and presents that vector to the tile's compute input with a valid/ready handshake. Two banks (ping-pong) let the next vector fill while the current one waits to be consumed, so one word per cycle is sustained.

---
 rtl/tile_pkg.sv | 19 +
 rtl/cast_gather_bank.sv | 54 +++++
 rtl/params.svh | 10 +
 rtl/cast_gather.sv | 80 ++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared types for the tile datapath: words, vectors, lane indices, bank states.
package tile_pkg;

  `include "params.svh"

  typedef logic [QW-1:0] qword_t;
  typedef qword_t [XW-1:0] qvec_t;

  // Lane index width; a single-lane vector still needs one bit of counter.
  localparam int CW = (XW > 1) ? $clog2(XW) : 1;
  typedef logic [CW-1:0] lane_idx_t;

  // A bank is either being filled (or idle) or holding a complete vector.
  typedef enum logic {
    BANK_FILL = 1'b0,
    BANK_FULL = 1'b1
  } bank_state_e;

endpackage

// File: rtl/cast_gather_bank.sv
// One ping-pong bank: lane storage, its FILL/FULL state and zero-masked read port.
module cast_gather_bank
  import tile_pkg::*;
#(
  parameter int valid_chans = 128
) (
  input  logic                    clk_tl,
  input  logic                    rstn_tl,
  input  logic                    wr_en,
  input  logic [CW-1:0]           wr_idx,
  input  logic [QW-1:0]           wr_data,
  input  logic                    set_full,
  input  logic                    clr_full,
  output logic                    full,
  output logic [XW-1:0][QW-1:0]   rd_data
);

  bank_state_e state_reg;

  // Only lanes that can ever be written get storage; the rest read as zero.
  for (genvar gi = 0; gi < XW; gi++) begin : g_lane
    if (gi < valid_chans) begin : g_used
      qword_t lane_reg;

      // Capture the word when this lane is the current write target.
      always_ff @(posedge clk_tl or negedge rstn_tl) begin
        if (!rstn_tl) begin
          lane_reg <= '0;
        end else if (wr_en && (wr_idx == lane_idx_t'(gi))) begin
          lane_reg <= wr_data;
        end
      end

      assign rd_data[gi] = lane_reg;
    end else begin : g_unused
      assign rd_data[gi] = '0;
    end
  end

  // Bank state: FILL until the last word lands, FULL until the vector is taken.
  always_ff @(posedge clk_tl or negedge rstn_tl) begin
    if (!rstn_tl) begin
      state_reg <= BANK_FILL;
    end else begin
      case (state_reg)
        BANK_FILL: if (set_full) state_reg <= BANK_FULL;
        BANK_FULL: if (clr_full) state_reg <= BANK_FILL;
      endcase
    end
  end

  assign full = (state_reg == BANK_FULL);

endmodule

// File: rtl/params.svh
// Tile-wide sizing shared by every block of the tile datapath.
`ifndef TILE_PARAMS_SVH
`define TILE_PARAMS_SVH

  // Width of one inbound word.
  localparam int QW = 16;
  // Number of lanes in one compute vector.
  localparam int XW = 128;

`endif

// File: rtl/cast_gather.sv
// Inbound word-to-vector deserializer with two ping-pong banks.
module cast_gather
  import tile_pkg::*;
#(
  parameter int valid_chans = 128
) (
  input  logic                    clk_tl,
  input  logic                    rstn_tl,
  input  logic [QW-1:0]           tl_data_i,
  input  logic                    tl_valid_i,
  output logic                    tl_ready_o,
  output logic [XW-1:0][QW-1:0]   vec_data_o,
  output logic                    vec_valid_o,
  input  logic                    vec_ready_i,
  output logic [1:0]              occ_o
);

  if (valid_chans < 1 || valid_chans > XW) begin : g_bad_valid_chans
    $error("cast_gather: valid_chans must lie in 1..XW");
  end

  logic      wbank;
  logic      rbank;
  lane_idx_t wcnt;
  logic [1:0] full;
  qvec_t     bank_data [2];

  logic wr_fire;
  logic rd_fire;
  logic last_word;

  // Ready and valid come straight from the registered bank flags.
  assign tl_ready_o  = ~full[wbank];
  assign vec_valid_o = full[rbank];
  assign wr_fire     = tl_valid_i & tl_ready_o;
  assign rd_fire     = vec_valid_o & vec_ready_i;
  assign last_word   = (wcnt == lane_idx_t'(valid_chans - 1));

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    cast_gather_bank #(
      .valid_chans(valid_chans)
    ) u_bank (
      .clk_tl   (clk_tl),
      .rstn_tl  (rstn_tl),
      .wr_en    (wr_fire && (wbank == 1'(gi))),
      .wr_idx   (wcnt),
      .wr_data  (tl_data_i),
      .set_full (wr_fire && last_word && (wbank == 1'(gi))),
      .clr_full (rd_fire && (rbank == 1'(gi))),
      .full     (full[gi]),
      .rd_data  (bank_data[gi])
    );
  end

  // Write lane counter and bank pointers advance only on handshakes.
  always_ff @(posedge clk_tl or negedge rstn_tl) begin
    if (!rstn_tl) begin
      wcnt  <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (last_word) begin
          wcnt  <= '0;
          wbank <= ~wbank;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
      if (rd_fire) begin
        rbank <= ~rbank;
      end
    end
  end

  // The read bank is never the write target while full, so its data holds steady.
  assign vec_data_o = bank_data[rbank];
  assign occ_o      = {1'b0, full[0]} + {1'b0, full[1]};

endmodule
